// File: rtl/mips_muldiv_if.sv
// Core-side bundle for the iterative multiply/divide unit:
// the start/op request, the MTHI/MTLO writes, and the HI/LO results with their status.
interface mips_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             mt_hi;
    logic             mt_lo;
    logic [WIDTH-1:0] mt_data;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b, mt_hi, mt_lo, mt_data,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, mt_hi, mt_lo, mt_data,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit that owns HI/LO. It uses a radix-2 shift-add multiply and
// a restoring divide over WIDTH cycles, then does one sign-fix cycle.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic           clk,
    input logic           reset,
    input logic           clock_enable,
    mips_muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic [WIDTH-1:0]   a_mag_q, a_mag_d;
    logic [WIDTH-1:0]   b_mag_q, b_mag_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [CW-1:0]      count_q, count_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic               qbit;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rmdr;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_a_d = neg_a_q;
        neg_b_d = neg_b_q;
        a_mag_d = a_mag_q;
        b_mag_d = b_mag_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = 1'b0;

        sum   = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_mag_q})
                         : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
        trial = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
        diff  = trial - {1'b0, b_mag_q};
        qbit  = ~diff[WIDTH];
        prod  = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quot  = (neg_a_q ^ neg_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rmdr  = neg_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    // Sign flags are only meaningful for the signed ops (op[0]=0).
                    op_d    = bus.op;
                    neg_a_d = ~bus.op[0] & bus.operand_a[WIDTH-1];
                    neg_b_d = ~bus.op[0] & bus.operand_b[WIDTH-1];
                    a_mag_d = neg_a_d ? -bus.operand_a : bus.operand_a;
                    b_mag_d = neg_b_d ? -bus.operand_b : bus.operand_b;
                    acc_d   = bus.op[1] ? {{WIDTH{1'b0}}, a_mag_d} : {{WIDTH{1'b0}}, b_mag_d};
                    rem_d   = '0;
                    count_d = CW'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    if (bus.mt_hi) hi_d = bus.mt_data;
                    if (bus.mt_lo) lo_d = bus.mt_data;
                end
            end
            S_RUN: begin
                if (!op_q[1]) begin
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                end else begin
                    rem_d = qbit ? diff : trial;
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], qbit};
                end
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (!op_q[1]) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (b_mag_q == '0) begin
                    // Rebuild operand_a from its magnitude rather than keeping a copy.
                    hi_d  = neg_a_q ? -a_mag_q : a_mag_q;
                    lo_d  = '1;
                    dbz_d = 1'b1;
                end else begin
                    hi_d = rmdr;
                    lo_d = quot;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clock_enable) begin
            if (reset) begin
                state_q <= S_IDLE;
                op_q    <= '0;
                neg_a_q <= 1'b0;
                neg_b_q <= 1'b0;
                a_mag_q <= '0;
                b_mag_q <= '0;
                acc_q   <= '0;
                rem_q   <= '0;
                count_q <= '0;
                hi_q    <= '0;
                lo_q    <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
                dbz_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                op_q    <= op_d;
                neg_a_q <= neg_a_d;
                neg_b_q <= neg_b_d;
                a_mag_q <= a_mag_d;
                b_mag_q <= b_mag_d;
                acc_q   <= acc_d;
                rem_q   <= rem_d;
                count_q <= count_d;
                hi_q    <= hi_d;
                lo_q    <= lo_d;
                busy_q  <= busy_d;
                done_q  <= done_d;
                dbz_q   <= dbz_d;
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed bench for mips_muldiv_unit: a table of operations with hand-computed HI/LO,
// plus sequences for MT writes, ignored requests, clock-enable stalls and reset aborts.
module tb_mips_muldiv_unit;
    logic clk;
    logic reset;
    logic clock_enable;

    mips_muldiv_if #(.WIDTH(32)) bus ();

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .clock_enable (clock_enable),
        .bus          (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[13];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int stall_len, input bit inject, input bit mt_with_start,
                          output int lat, output logic [31:0] h, output logic [31:0] l,
                          output logic [31:0] hi_e0, output logic d,
                          output bit busy_ok, output bit pulse_ok);
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.start     = 1'b1;
        if (mt_with_start) begin
            bus.mt_hi   = 1'b1;
            bus.mt_data = 32'h0000DEAD;
        end
        @(posedge clk); #1;
        bus.start     = 1'b0;
        bus.mt_hi     = 1'b0;
        bus.op        = ~op;
        bus.operand_a = ~a;
        bus.operand_b = ~b;
        hi_e0    = bus.hi;
        busy_ok  = (bus.busy === 1'b1);
        pulse_ok = 1'b0;
        lat      = -1;
        h        = '0;
        l        = '0;
        d        = 1'b0;
        for (int c = 1; c <= 100 && lat < 0; c++) begin
            if (stall_len > 0 && c == 11) clock_enable = 1'b0;
            if (stall_len > 0 && c == 11 + stall_len) clock_enable = 1'b1;
            if (inject && c == 11) begin
                bus.start     = 1'b1;
                bus.op        = 2'b11;
                bus.operand_a = 32'd9;
                bus.operand_b = 32'd0;
                bus.mt_lo     = 1'b1;
                bus.mt_data   = 32'h0000AAAA;
            end
            if (inject && c == 12) begin
                bus.start = 1'b0;
                bus.mt_lo = 1'b0;
            end
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                lat     = c;
                h       = bus.hi;
                l       = bus.lo;
                d       = bus.div_by_zero;
                busy_ok = busy_ok && (bus.busy === 1'b0);
            end else begin
                busy_ok = busy_ok && (bus.busy === 1'b1) && (bus.div_by_zero === 1'b0);
            end
        end
        clock_enable = 1'b1;
        if (lat > 0) begin
            @(posedge clk); #1;
            pulse_ok = (bus.done === 1'b0) && (bus.div_by_zero === 1'b0);
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] h, l, hi_e0;
        logic        d;
        bit          busy_ok, pulse_ok;
        bit          any_done;

        vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[4]  = '{2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[6]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[7]  = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
        vecs[8]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[9]  = '{2'b10, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
        vecs[10] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        vecs[11] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[12] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};

        reset         = 1'b1;
        clock_enable  = 1'b1;
        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.mt_hi     = 1'b0;
        bus.mt_lo     = 1'b0;
        bus.mt_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset hi", 64'(bus.hi), 64'h0);
        check("reset lo", 64'(bus.lo), 64'h0);
        check("reset busy", 64'(bus.busy), 64'h0);
        check("reset done", 64'(bus.done), 64'h0);
        check("reset dbz", 64'(bus.div_by_zero), 64'h0);
        reset = 1'b0;

        bus.mt_hi   = 1'b1;
        bus.mt_data = 32'h00001234;
        @(posedge clk); #1;
        bus.mt_hi = 1'b0;
        check("mthi hi", 64'(bus.hi), 64'h1234);
        check("mthi lo untouched", 64'(bus.lo), 64'h0);
        bus.mt_hi   = 1'b1;
        bus.mt_lo   = 1'b1;
        bus.mt_data = 32'h00005555;
        @(posedge clk); #1;
        bus.mt_hi = 1'b0;
        bus.mt_lo = 1'b0;
        check("mt both hi", 64'(bus.hi), 64'h5555);
        check("mt both lo", 64'(bus.lo), 64'h5555);

        clock_enable = 1'b0;
        reset        = 1'b1;
        @(posedge clk); #1;
        check("ce low blocks reset", 64'(bus.hi), 64'h5555);
        reset        = 1'b0;
        clock_enable = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 1'b0, 1'b0,
                   lat, h, l, hi_e0, d, busy_ok, pulse_ok);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'd33);
            check($sformatf("vec%0d hi", i), 64'(h), 64'(vecs[i].hi));
            check($sformatf("vec%0d lo", i), 64'(l), 64'(vecs[i].lo));
            check($sformatf("vec%0d dbz", i), 64'(d), 64'(vecs[i].dbz));
            check($sformatf("vec%0d busy during run", i), 64'(busy_ok), 64'h1);
            check($sformatf("vec%0d single pulse", i), 64'(pulse_ok), 64'h1);
        end

        bus.mt_hi   = 1'b1;
        bus.mt_data = 32'h00001234;
        @(posedge clk); #1;
        bus.mt_hi = 1'b0;
        run_op(2'b01, 32'd3, 32'd4, 0, 1'b1, 1'b0, lat, h, l, hi_e0, d, busy_ok, pulse_ok);
        check("ignored start latency", 64'(lat), 64'd33);
        check("ignored start hi", 64'(h), 64'h0);
        check("ignored start lo", 64'(l), 64'd12);
        check("ignored start dbz", 64'(d), 64'h0);
        check("ignored start pulse", 64'(pulse_ok), 64'h1);

        run_op(2'b10, 32'd100, 32'd7, 5, 1'b0, 1'b0, lat, h, l, hi_e0, d, busy_ok, pulse_ok);
        check("stall latency", 64'(lat), 64'd38);
        check("stall hi", 64'(h), 64'd2);
        check("stall lo", 64'(l), 64'd14);
        check("stall busy", 64'(busy_ok), 64'h1);

        run_op(2'b01, 32'd2, 32'd3, 0, 1'b0, 1'b1, lat, h, l, hi_e0, d, busy_ok, pulse_ok);
        check("start beats mthi", 64'(hi_e0), 64'd2);
        check("start+mt hi", 64'(h), 64'h0);
        check("start+mt lo", 64'(l), 64'd6);

        bus.mt_hi   = 1'b1;
        bus.mt_data = 32'h00001234;
        @(posedge clk); #1;
        bus.mt_hi     = 1'b0;
        bus.op        = 2'b10;
        bus.operand_a = 32'd100;
        bus.operand_b = 32'd7;
        bus.start     = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort busy", 64'(bus.busy), 64'h0);
        check("abort done", 64'(bus.done), 64'h0);
        check("abort hi", 64'(bus.hi), 64'h0);
        check("abort lo", 64'(bus.lo), 64'h0);
        any_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) any_done = 1'b1;
        end
        check("no done after abort", 64'(any_done), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
Iterative multiply/divide unit that owns the HI/LO register pair for the MIPS core. It replaces the single-cycle combinational mult/div path.
- Executes MULT, MULTU, DIV and DIVU with a radix-2 shift-add / restoring-divide datapath over WIDTH cycles.
- Supports MTHI/MTLO writes.
- Exposes a start/busy/done handshake so the core can stall MFHI/MFLO until results are valid.

Parameters:
WIDTH, 32, operand and HI/LO register width in bits (must be >= 4).

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high; clock clk
clock_enable  input  1  when low, all state (including counters, HI, LO, done) holds
start  input  1  request a new operation; sampled only when busy=0
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
operand_a  input  WIDTH  rs value (multiplicand / dividend); sampled with start
operand_b  input  WIDTH  rt value (multiplier / divisor); sampled with start
mt_hi  input  1  MTHI: load HI from mt_data
mt_lo  input  1  MTLO: load LO from mt_data
mt_data  input  WIDTH  data for MTHI/MTLO
busy  output  1  operation in progress
done  output  1  one-cycle pulse: HI/LO just updated by a completed operation
div_by_zero  output  1  valid with done: the completed DIV/DIVU had operand_b=0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (clock_enable=1 at edge):
  - state IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0.
  - Reset mid-operation aborts; no partial result reaches HI/LO.
- clock_enable=0: no state changes, including reset; outputs hold.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 at edge E0 captures op, sign flags and |a|, |b|.
    - Unsigned ops and non-negative signed operands: raw value.
    - Negative signed operands: two's-complement magnitude, WIDTH bits, treated as unsigned.
  - At E0: count=WIDTH, busy<=1, state->RUN.
- RUN:
  - One iteration per enabled edge; count decrements; after WIDTH iterations, state->FIX.
  - Multiply: 2*WIDTH-bit accumulator, shift-add on LSB of multiplier.
  - Divide: restoring; partial remainder WIDTH+1 bits, quotient shifted in MSB-first.
- FIX (single edge, E0+WIDTH+1):
  - Applies result signs; writes HI/LO; busy<=0; done<=1 for exactly one cycle; state->IDLE.
- Latency: done is high in the cycle after edge E0+WIDTH+1. With WIDTH=32, that is 33 enabled cycles after the start edge.
- Results:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH product. Signed product negated if operand signs differ.
  - DIV/DIVU: lo=quotient, hi=remainder.
  - Signed quotient truncates toward zero. Remainder takes the sign of the dividend.
- Signed overflow, most-negative / -1: lo=most-negative (0x80000000 at WIDTH=32), hi=0, div_by_zero=0.
- Divide by zero:
  - Full latency still taken.
  - hi=operand_a as captured, lo=all ones.
  - div_by_zero=1 for the done cycle only; it is 0 whenever done=0.
- start while busy=1: ignored; the operation in flight is unaffected.
- MTHI/MTLO:
  - When busy=0, mt_hi/mt_lo write HI/LO at the next edge (1-cycle latency); both may assert together.
  - When busy=1, they are ignored.
  - start and mt_* in the same IDLE cycle: start is taken, mt_* ignored.
- hi/lo change only on reset, FIX, or an accepted MT write. Reads (MFHI/MFLO) are the hi/lo outputs directly.
- No combinational path from inputs to any output; all outputs are registered.

Test Plan:
- Reset, then MULT a=0xFFFFFFFD (-3), b=7 -> busy=1 for 33 cycles; done pulses once with hi=0xFFFFFFFF, lo=0xFFFFFFEB; div_by_zero=0.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- Signed edge cases:
  - DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU a=5, b=0 -> hi=5, lo=0xFFFFFFFF, div_by_zero=1 only in the done cycle.
- Handshake and hold behaviour:
  - MTHI 0x1234 with busy=0 -> hi=0x1234 next cycle.
  - Start MULTU 3*4, then pulse start (op DIVU) and mt_lo 0xAAAA mid-run -> both ignored; final hi=0, lo=12.
  - Drop clock_enable for 5 cycles mid-run -> done is delayed by exactly 5 cycles, result unchanged.
- Reset asserted 10 cycles into DIV 100/7 -> busy=0, done=0, hi=lo=0 next edge; no done pulse follows.
